// File: rtl/cache_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cache_fsm
// Purpose  : Write-back / write-allocate cache controller. It serves hits
//            combinationally from IDLE. On a miss it writes a dirty victim
//            line back word by word, then refills the line from memory word
//            by word.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          in   1          clock, rising edge
//   rst_i          in   1          asynchronous active-low reset
//   read_en_i      in   1          processor read request
//   write_en_i     in   1          processor write request (wins over read)
//   addr_i         in   32         processor address
//   hit_i          in   1          indexed set hits
//   dirty_i        in   1          victim line is dirty
//   victim_tag_i   in   TAG_WIDTH  tag of the victim line
//   mem_ready_i    in   1          memory accepted/returned the current word
//   control_o      out  5          {write_en, set_valid, set_dirty,
//                                   strategy_en, offset_sel} to the sets
//   mem_read_en_o  out  1          memory read strobe
//   mem_write_en_o out  1          memory write strobe
//   mem_addr_o     out  32         word address to memory and set offset mux
//   stall_o        out  1          processor must hold its request
//   hit_count_o    out  32         saturating hit counter (stats build only)
//   miss_count_o   out  32         saturating miss counter (stats build only)
// ----------------------------------------------------------------------------
// Build option
//   CACHE_STATS_EN : when defined, the hit/miss counters are built. When it
//                    is undefined, both count outputs are tied to zero.
// ============================================================================
module cache_fsm #(
    parameter int TAG_WIDTH    = 26,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 read_en_i,
    input  logic                 write_en_i,
    input  logic [31:0]          addr_i,
    input  logic                 hit_i,
    input  logic                 dirty_i,
    input  logic [TAG_WIDTH-1:0] victim_tag_i,
    input  logic                 mem_ready_i,
    output logic [4:0]           control_o,
    output logic                 mem_read_en_o,
    output logic                 mem_write_en_o,
    output logic [31:0]          mem_addr_o,
    output logic                 stall_o,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o
);

    // Word counter width: one count per 32-bit word in a line
    localparam int              CNT_W      = OFFSET_WIDTH - 2;
    localparam logic [CNT_W-1:0] c_CNT_LAST = '1;

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_WRITE_BACK = 2'd1;
    localparam logic [1:0] c_ALLOCATE   = 2'd2;

    localparam logic [4:0] c_CTRL_IDLE   = 5'b00001;
    localparam logic [4:0] c_CTRL_RHIT   = 5'b00011;
    localparam logic [4:0] c_CTRL_WHIT   = 5'b11111;
    localparam logic [4:0] c_CTRL_NONE   = 5'b00000;
    localparam logic [4:0] c_CTRL_FILL   = 5'b10000;
    localparam logic [4:0] c_CTRL_FILL_L = 5'b11000;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_req;
    logic w_miss;
    logic w_last;

    assign w_req  = read_en_i | write_en_i;
    assign w_miss = (r_state == c_IDLE) && w_req && !hit_i;
    assign w_last = (r_cnt == c_CNT_LAST) && mem_ready_i;

    // The low offset bits never reach the memory address (word aligned)
    logic w_unused_offset;
    assign w_unused_offset = ^addr_i[OFFSET_WIDTH-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Word counter. It is cleared on entry to a miss and advances only on
    // accepted words. WORDS is a power of two, so after the last write-back
    // word it wraps to 0 by itself, ready for the refill.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (w_miss) begin
            r_cnt <= '0;
        end else if ((r_state != c_IDLE) && mem_ready_i) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_miss) begin
                    w_next_state = dirty_i ? c_WRITE_BACK : c_ALLOCATE;
                end
            end
            c_WRITE_BACK: begin
                if (w_last) begin
                    w_next_state = c_ALLOCATE;
                end
            end
            c_ALLOCATE: begin
                if (w_last) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. The outputs are gated by reset directly, so the idle
    // values show up at the same instant rst_i falls, even when a request
    // with hit_i is present.
    // ------------------------------------------------------------------
    always_comb begin
        control_o      = c_CTRL_IDLE;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        mem_addr_o     = '0;
        stall_o        = 1'b0;
        if (rst_i) begin
            case (r_state)
                c_IDLE: begin
                    if (!w_req) begin
                        control_o = c_CTRL_IDLE;
                    end else if (hit_i) begin
                        control_o = write_en_i ? c_CTRL_WHIT : c_CTRL_RHIT;
                    end else begin
                        control_o = c_CTRL_NONE;
                        stall_o   = 1'b1;
                    end
                end
                c_WRITE_BACK: begin
                    control_o      = c_CTRL_NONE;
                    mem_write_en_o = 1'b1;
                    stall_o        = 1'b1;
                    mem_addr_o     = {victim_tag_i,
                                      addr_i[31-TAG_WIDTH:OFFSET_WIDTH],
                                      r_cnt, 2'b00};
                end
                c_ALLOCATE: begin
                    mem_read_en_o = 1'b1;
                    stall_o       = 1'b1;
                    mem_addr_o    = {addr_i[31:OFFSET_WIDTH], r_cnt, 2'b00};
                    if (mem_ready_i) begin
                        control_o = (r_cnt == c_CNT_LAST) ? c_CTRL_FILL_L
                                                          : c_CTRL_FILL;
                    end else begin
                        control_o = c_CTRL_NONE;
                    end
                end
                default: begin
                    control_o = c_CTRL_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic        w_hit_evt;

    assign w_hit_evt = (r_state == c_IDLE) && w_req && hit_i;

    // Both counters saturate rather than wrap
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_evt && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count_o  = r_hit_count;
    assign miss_count_o = r_miss_count;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fsm
// Purpose  : Self-checking bench for cache_fsm (TAG_WIDTH=26, OFFSET_WIDTH=4).
//            Each driven cycle pushes its expected outputs into a scoreboard
//            queue. The values are popped and compared on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fsm;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        read_en_i;
    logic        write_en_i;
    logic [31:0] addr_i;
    logic        hit_i;
    logic        dirty_i;
    logic [25:0] victim_tag_i;
    logic        mem_ready_i;
    logic [4:0]  control_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [31:0] mem_addr_o;
    logic        stall_o;
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    typedef struct {
        logic [4:0]  ctrl;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic        stall;
        logic [31:0] hc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb_q[$];

    cache_fsm #(
        .TAG_WIDTH    (26),
        .OFFSET_WIDTH (4)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .read_en_i      (read_en_i),
        .write_en_i     (write_en_i),
        .addr_i         (addr_i),
        .hit_i          (hit_i),
        .dirty_i        (dirty_i),
        .victim_tag_i   (victim_tag_i),
        .mem_ready_i    (mem_ready_i),
        .control_o      (control_o),
        .mem_read_en_o  (mem_read_en_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_addr_o     (mem_addr_o),
        .stall_o        (stall_o),
        .hit_count_o    (hit_count_o),
        .miss_count_o   (miss_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected in it.
    // inc_h/inc_m record that this cycle is a counted hit/miss event.
    // The count becomes visible from the following cycle onward.
    task automatic step(input logic rst, input logic rd, input logic wr,
                        input logic [31:0] a, input logic hit, input logic dirty,
                        input logic [25:0] vt, input logic rdy,
                        input logic [4:0] ec, input logic erd, input logic ewr,
                        input logic [31:0] ea, input logic es,
                        input logic inc_h, input logic inc_m);
        exp_t e;
        @(posedge clk);
        #1;
        rst_i        = rst;
        read_en_i    = rd;
        write_en_i   = wr;
        addr_i       = a;
        hit_i        = hit;
        dirty_i      = dirty;
        victim_tag_i = vt;
        mem_ready_i  = rdy;
        if (!rst) begin
            exp_hits   = 0;
            exp_misses = 0;
        end
        e.ctrl  = ec;
        e.rd    = erd;
        e.wr    = ewr;
        e.addr  = ea;
        e.stall = es;
`ifdef CACHE_STATS_EN
        e.hc = exp_hits;
        e.mc = exp_misses;
`else
        e.hc = 32'd0;
        e.mc = 32'd0;
`endif
        sb_q.push_back(e);
        if (inc_h) exp_hits++;
        if (inc_m) exp_misses++;
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("control_o",      {27'd0, control_o},     {27'd0, e.ctrl});
            check("mem_read_en_o",  {31'd0, mem_read_en_o}, {31'd0, e.rd});
            check("mem_write_en_o", {31'd0, mem_write_en_o},{31'd0, e.wr});
            check("mem_addr_o",     mem_addr_o,             e.addr);
            check("stall_o",        {31'd0, stall_o},       {31'd0, e.stall});
            check("hit_count_o",    hit_count_o,            e.hc);
            check("miss_count_o",   miss_count_o,           e.mc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; read_en_i = 1'b0; write_en_i = 1'b0; addr_i = '0;
        hit_i = 1'b0; dirty_i = 1'b0; victim_tag_i = '0; mem_ready_i = 1'b0;

        // Reset holds idle outputs even with a hitting read present
        step(0, 1, 0, 32'h1004, 1, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0000, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 32'h0000, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0);

        // Hits: read, write, read+write treated as write
        step(1, 1, 0, 32'h1004, 1, 0, 0, 0, 5'b00011, 0, 0, 0, 0, 1, 0);
        step(1, 0, 1, 32'h1004, 1, 0, 0, 0, 5'b11111, 0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 32'h1008, 1, 0, 0, 0, 5'b11111, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 32'h0000, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0);

        // Clean read miss at 0x1000
        step(1, 1, 0, 32'h1000, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 32'h1000, 0, 0, 0, 1, (i == 3) ? 5'b11000 : 5'b10000,
                 1, 0, 32'h1000 + 32'(4 * i), 1, 0, 0);
        step(1, 1, 0, 32'h1000, 1, 0, 0, 1, 5'b00011, 0, 0, 0, 0, 1, 0);

        // Dirty miss at 0x1010, victim tag 2
        step(1, 1, 0, 32'h1010, 0, 1, 26'd2, 1, 5'b00000, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 32'h1010, 0, 1, 26'd2, 1, 5'b00000,
                 0, 1, 32'h0090 + 32'(4 * i), 1, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 32'h1010, 0, 1, 26'd2, 1, (i == 3) ? 5'b11000 : 5'b10000,
                 1, 0, 32'h1010 + 32'(4 * i), 1, 0, 0);
        step(1, 1, 0, 32'h1010, 1, 0, 26'd2, 1, 5'b00011, 0, 0, 0, 0, 1, 0);

        // Write miss, memory stalls after the second word, request withdrawn
        step(1, 0, 1, 32'h1000, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 1, 0, 1);
        step(1, 0, 1, 32'h1000, 0, 0, 0, 1, 5'b10000, 1, 0, 32'h1000, 1, 0, 0);
        step(1, 0, 1, 32'h1000, 0, 0, 0, 1, 5'b10000, 1, 0, 32'h1004, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 32'h1000, 0, 0, 0, 0, 5'b00000, 1, 0, 32'h1008, 1, 0, 0);
        step(1, 0, 0, 32'h1000, 0, 0, 0, 1, 5'b10000, 1, 0, 32'h1008, 1, 0, 0);
        step(1, 0, 0, 32'h1000, 0, 0, 0, 1, 5'b11000, 1, 0, 32'h100C, 1, 0, 0);
        step(1, 0, 0, 32'h1000, 0, 0, 0, 1, 5'b00001, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a refill
        step(1, 1, 0, 32'h1000, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 1, 0, 1);
        step(1, 1, 0, 32'h1000, 0, 0, 0, 1, 5'b10000, 1, 0, 32'h1000, 1, 0, 0);
        step(1, 1, 0, 32'h1000, 0, 0, 0, 0, 5'b00000, 1, 0, 32'h1004, 1, 0, 0);
        step(0, 1, 0, 32'h1000, 0, 0, 0, 1, 5'b00001, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 32'h1000, 0, 0, 0, 1, 5'b00001, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 32'h1004, 1, 0, 0, 0, 5'b00011, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 32'h0000, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
